angle_search_ctrl: RTL and testbench
====================================

// Module: angle_search_ctrl
// PURPOSE
//  Parametrised successor to the matching control unit. Sweeps N_CAND candidate (theta,phi)
//  pairs, and ALPHA_STEPS alpha values per pair. Issues one score request per triple to the
//  external scoring datapath over a valid/ready handshake, then waits for the returned score.
//  Tracks the arg-max and reports the best angle triple with a one-cycle done pulse.
//  Sits between the candidate-angle buffer and the point-transform/score pipeline.
// PARAMETERS
//  ANGLE_W      12   width of theta, phi, alpha
//  N_CAND       10   candidate pairs in cand_buf (>=1)
//  ALPHA_STEPS  360  alpha values swept per candidate (>=1)
//  ALPHA_INC    1    alpha increment per step; (ALPHA_STEPS-1)*ALPHA_INC must fit ANGLE_W
//  SCORE_W      16   unsigned score width
// PORTS
//  clk          in   1                  clock, rising edge
//  rst          in   1                  synchronous reset, active-high
//  start        in   1                  begin search (sampled in IDLE only)
//  abort        in   1                  cancel search, any state
//  cand_buf     in   N_CAND*2*ANGLE_W   entry i at [i*2*ANGLE_W +: 2*ANGLE_W] = {theta,phi}
//  req_valid    out  1                  request triple valid
//  req_ready    in   1                  scorer accepts request
//  theta,phi,alpha out ANGLE_W          request triple, stable while req_valid && !req_ready
//  last_angle   out  1                  high with req_valid on final candidate's final alpha
//  cand_idx     out  clog2(N_CAND)      index of candidate being requested
//  score_valid  in   1                  score returned for outstanding request
//  score        in   SCORE_W            returned score
//  busy         out  1                  high in every state except IDLE
//  done         out  1                  one-cycle pulse, results valid
//  best_theta,best_phi,best_alpha out ANGLE_W  arg-max triple
//  best_score   out  SCORE_W            maximum score
//  best_idx     out  clog2(N_CAND)      candidate index of maximum
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; internal counters 0.
//  FSM: IDLE -start-> ISSUE -req_ready-> WAIT -score_valid-> UPDATE -> ISSUE | DONE -> IDLE.
//  Start handling:
//   - start in IDLE snapshots cand_buf into an internal register.
//   - Later cand_buf changes are ignored until the next start.
//   - start while busy is ignored.
//  ISSUE: req_valid=1; theta/phi from snapshot[cand_idx]; alpha=step*ALPHA_INC.
//  At most one request is outstanding.
//  score_valid outside WAIT is ignored; it may arrive the cycle after acceptance or later.
//  UPDATE, best-tracking:
//   - The first score of a run is always taken.
//   - A later score replaces the best only if strictly greater, so ties keep the earliest
//     triple (lower cand_idx, then lower alpha).
//  UPDATE, sweep advance:
//   - alpha step increments.
//   - At ALPHA_STEPS-1 the step wraps to 0 and cand_idx increments.
//   - After the final triple, go to DONE.
//  DONE: done=1 for one cycle, then IDLE. best_* hold until the next start.
//  best_* clear to 0 on the first UPDATE of a new run, not on start.
//  Latency:
//   - start@t -> req_valid@t+1.
//   - accept@t, score_valid@t+1 -> UPDATE@t+2 -> next req_valid@t+3.
//   - final UPDATE@u -> done@u+1.
//  Abort, any busy state: IDLE next cycle.
//   - req_valid drops immediately after.
//   - No done pulse; best_* keep last committed values.
//   - An in-flight score is dropped.
//  abort with start in IDLE: abort wins, stays IDLE.
//  rst mid-run: same as power-on reset, with immediate effect.
//  Widths: index counters sized $clog2 with a minimum of 1 bit. Comparison is unsigned.
// STRUCTURE
//  angle_search_defs.vh: FSM state localparams and a CLOG2 helper macro.
//  This file holds the FSM, the sweep counters and the snapshot register.
//  Sub-module best_tracker holds the arg-max compare/commit logic:
//   - inputs: first, commit, score, triple, idx.
//   - outputs: best_*.
// TESTING
//  1. N_CAND=2, ALPHA_STEPS=3, ready=1, score=1-cycle echo of (cand_idx*10+alpha)
//     -> 6 requests; done once; best=(cand1, alpha2, score 12).
//  2. All scores equal 5 -> best_idx=0, best_alpha=0, best_score=5 (earliest wins tie).
//  3. req_ready low for 4 cycles -> theta/phi/alpha/req_valid stable; no skipped triple.
//  4. abort while in WAIT -> busy low next cycle; no done; stray score_valid ignored;
//     previous best_* unchanged.
//  5. cand_buf changed mid-run -> requests use the start snapshot values.
//  6. start held high through run -> after done and one IDLE cycle, a second run begins;
//     rst mid-run -> all outputs 0 next cycle.

Source files
------------

// File: rtl/angle_search_ctrl_pkg.sv
// Shared types for the angle search controller: FSM state encoding and a
// width helper for index counters that must never collapse to zero bits.
package angle_search_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_WAIT   = 3'd2,
    S_UPDATE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/angle_search_ctrl_best_tracker.sv
// Arg-max register for the angle search: holds the best score seen in the
// current run and the triple/index that produced it.
module angle_search_ctrl_best_tracker
  import angle_search_ctrl_pkg::*;
#(
  parameter int ANGLE_W = 12,
  parameter int SCORE_W = 16,
  parameter int IDX_W   = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               first_i,
  input  logic               commit_i,
  input  logic [SCORE_W-1:0] score_i,
  input  logic [ANGLE_W-1:0] theta_i,
  input  logic [ANGLE_W-1:0] phi_i,
  input  logic [ANGLE_W-1:0] alpha_i,
  input  logic [IDX_W-1:0]   idx_i,
  output logic [ANGLE_W-1:0] best_theta_o,
  output logic [ANGLE_W-1:0] best_phi_o,
  output logic [ANGLE_W-1:0] best_alpha_o,
  output logic [SCORE_W-1:0] best_score_o,
  output logic [IDX_W-1:0]   best_idx_o
);

  logic [ANGLE_W-1:0] best_theta_q, best_phi_q, best_alpha_q;
  logic [SCORE_W-1:0] best_score_q;
  logic [IDX_W-1:0]   best_idx_q;
  logic               take;

  // Strictly-greater compare keeps the earliest triple on ties.
  assign take = commit_i && (first_i || (score_i > best_score_q));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      best_theta_q <= '0;
      best_phi_q   <= '0;
      best_alpha_q <= '0;
      best_score_q <= '0;
      best_idx_q   <= '0;
    end else if (take) begin
      best_theta_q <= theta_i;
      best_phi_q   <= phi_i;
      best_alpha_q <= alpha_i;
      best_score_q <= score_i;
      best_idx_q   <= idx_i;
    end
  end

  assign best_theta_o = best_theta_q;
  assign best_phi_o   = best_phi_q;
  assign best_alpha_o = best_alpha_q;
  assign best_score_o = best_score_q;
  assign best_idx_o   = best_idx_q;

endmodule

// File: rtl/angle_search_ctrl.sv
// Sweeps candidate (theta,phi) pairs x alpha steps, requests a score per triple
// and reports the arg-max triple with a one-cycle done pulse.
//   state    | meaning
//   S_IDLE   | waiting for start; candidate snapshot taken on start
//   S_ISSUE  | req_valid high, waiting for req_ready
//   S_WAIT   | one request outstanding, waiting for score_valid
//   S_UPDATE | commit score to tracker, advance alpha/candidate counters
//   S_DONE   | one-cycle done pulse
module angle_search_ctrl
  import angle_search_ctrl_pkg::*;
#(
  parameter int ANGLE_W     = 12,
  parameter int N_CAND      = 10,
  parameter int ALPHA_STEPS = 360,
  parameter int ALPHA_INC   = 1,
  parameter int SCORE_W     = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          start_i,
  input  logic                          abort_i,
  input  logic [N_CAND*2*ANGLE_W-1:0]   cand_buf_i,
  output logic                          req_valid_o,
  input  logic                          req_ready_i,
  output logic [ANGLE_W-1:0]            theta_o,
  output logic [ANGLE_W-1:0]            phi_o,
  output logic [ANGLE_W-1:0]            alpha_o,
  output logic                          last_angle_o,
  output logic [idx_width(N_CAND)-1:0]  cand_idx_o,
  input  logic                          score_valid_i,
  input  logic [SCORE_W-1:0]            score_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic [ANGLE_W-1:0]            best_theta_o,
  output logic [ANGLE_W-1:0]            best_phi_o,
  output logic [ANGLE_W-1:0]            best_alpha_o,
  output logic [SCORE_W-1:0]            best_score_o,
  output logic [idx_width(N_CAND)-1:0]  best_idx_o
);

  localparam int IDX_W  = idx_width(N_CAND);
  localparam int STEP_W = idx_width(ALPHA_STEPS);
  localparam int PAIR_W = 2 * ANGLE_W;

  state_t                     state_q, state_d;
  logic [N_CAND*PAIR_W-1:0]   snap_q;
  logic [IDX_W-1:0]           cand_q, cand_d;
  logic [STEP_W-1:0]          step_q, step_d;
  logic [SCORE_W-1:0]         score_q, score_d;
  logic [PAIR_W-1:0]          pair;
  logic [ANGLE_W-1:0]         alpha_cur;
  logic                       last_cand, last_step, commit, launch;

  assign launch    = (state_q == S_IDLE) && start_i && !abort_i;
  assign last_cand = (cand_q == IDX_W'(N_CAND - 1));
  assign last_step = (step_q == STEP_W'(ALPHA_STEPS - 1));
  assign alpha_cur = ANGLE_W'(32'(step_q) * ALPHA_INC);

  always_comb begin
    pair = '0;
    for (int i = 0; i < N_CAND; i++) begin
      if (cand_q == IDX_W'(i)) pair = snap_q[i*PAIR_W +: PAIR_W];
    end
  end

  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    step_d      = step_q;
    score_d     = score_q;
    commit      = 1'b0;
    req_valid_o = 1'b0;
    done_o      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (launch) begin
          state_d = S_ISSUE;
          cand_d  = '0;
          step_d  = '0;
        end
      end
      S_ISSUE: begin
        req_valid_o = 1'b1;
        if (req_ready_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (score_valid_i) begin
          score_d = score_i;
          state_d = S_UPDATE;
        end
      end
      S_UPDATE: begin
        commit  = 1'b1;
        state_d = S_ISSUE;
        if (!last_step) begin
          step_d = step_q + STEP_W'(1);
        end else begin
          step_d = '0;
          if (last_cand) begin
            cand_d  = '0;
            state_d = S_DONE;
          end else begin
            cand_d = cand_q + IDX_W'(1);
          end
        end
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Abort beats every other transition, including a pending commit.
    if (abort_i && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      commit  = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      snap_q  <= '0;
      cand_q  <= '0;
      step_q  <= '0;
      score_q <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      step_q  <= step_d;
      score_q <= score_d;
      if (launch) snap_q <= cand_buf_i;
    end
  end

  assign theta_o      = req_valid_o ? pair[PAIR_W-1 -: ANGLE_W] : '0;
  assign phi_o        = req_valid_o ? pair[ANGLE_W-1:0] : '0;
  assign alpha_o      = req_valid_o ? alpha_cur : '0;
  assign last_angle_o = req_valid_o && last_cand && last_step;
  assign cand_idx_o   = cand_q;
  assign busy_o       = (state_q != S_IDLE);

  angle_search_ctrl_best_tracker #(
    .ANGLE_W (ANGLE_W),
    .SCORE_W (SCORE_W),
    .IDX_W   (IDX_W)
  ) u_best (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .first_i      ((cand_q == '0) && (step_q == '0)),
    .commit_i     (commit),
    .score_i      (score_q),
    .theta_i      (pair[PAIR_W-1 -: ANGLE_W]),
    .phi_i        (pair[ANGLE_W-1:0]),
    .alpha_i      (alpha_cur),
    .idx_i        (cand_q),
    .best_theta_o (best_theta_o),
    .best_phi_o   (best_phi_o),
    .best_alpha_o (best_alpha_o),
    .best_score_o (best_score_o),
    .best_idx_o   (best_idx_o)
  );

endmodule

// File: tb/tb_angle_search_ctrl.sv
// Self-checking bench for angle_search_ctrl: directed runs with random angles,
// scores and handshake timing, checked against a loop-level sweep/arg-max model.
module tb_angle_search_ctrl;

  localparam int ANGLE_W     = 12;
  localparam int N_CAND      = 2;
  localparam int ALPHA_STEPS = 3;
  localparam int ALPHA_INC   = 1;
  localparam int SCORE_W     = 16;
  localparam int IDX_W       = 1;

  logic                        clk = 1'b0;
  logic                        rst, start, abort, req_ready, score_valid;
  logic [N_CAND*2*ANGLE_W-1:0] cand_buf;
  logic [SCORE_W-1:0]          score;
  logic                        req_valid, last_angle, busy, done;
  logic [ANGLE_W-1:0]          theta, phi, alpha, best_theta, best_phi, best_alpha;
  logic [IDX_W-1:0]            cand_idx, best_idx;
  logic [SCORE_W-1:0]          best_score;

  angle_search_ctrl #(
    .ANGLE_W(ANGLE_W), .N_CAND(N_CAND), .ALPHA_STEPS(ALPHA_STEPS),
    .ALPHA_INC(ALPHA_INC), .SCORE_W(SCORE_W)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
    .cand_buf_i(cand_buf), .req_valid_o(req_valid), .req_ready_i(req_ready),
    .theta_o(theta), .phi_o(phi), .alpha_o(alpha), .last_angle_o(last_angle),
    .cand_idx_o(cand_idx), .score_valid_i(score_valid), .score_i(score),
    .busy_o(busy), .done_o(done), .best_theta_o(best_theta), .best_phi_o(best_phi),
    .best_alpha_o(best_alpha), .best_score_o(best_score), .best_idx_o(best_idx)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference state: snapshot of the pairs for the current run and the best so far.
  logic [ANGLE_W-1:0] m_theta [N_CAND];
  logic [ANGLE_W-1:0] m_phi   [N_CAND];
  logic [ANGLE_W-1:0] mb_theta, mb_phi, mb_alpha;
  logic [SCORE_W-1:0] mb_score;
  int                 mb_idx;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_best(input string tag);
    check({tag, "_best_theta"}, 32'(best_theta), 32'(mb_theta));
    check({tag, "_best_phi"},   32'(best_phi),   32'(mb_phi));
    check({tag, "_best_alpha"}, 32'(best_alpha), 32'(mb_alpha));
    check({tag, "_best_score"}, 32'(best_score), 32'(mb_score));
    check({tag, "_best_idx"},   32'(best_idx),   32'(mb_idx));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_valid"}, 32'(req_valid), 0);
    check({tag, "_busy"},      32'(busy), 0);
    check({tag, "_done"},      32'(done), 0);
    check({tag, "_theta"},     32'(theta), 0);
    check({tag, "_phi"},       32'(phi), 0);
    check({tag, "_alpha"},     32'(alpha), 0);
    check({tag, "_last"},      32'(last_angle), 0);
    check({tag, "_cand_idx"},  32'(cand_idx), 0);
    mb_theta = '0; mb_phi = '0; mb_alpha = '0; mb_score = '0; mb_idx = 0;
    check_best(tag);
  endtask

  // smode: 0 = cand*10+alpha echo, 1 = constant 5, 2 = random with stray score pulses
  task automatic do_run(input string tag, input int smode, input int stall,
                        input int abort_k, input bit hold);
    logic [N_CAND*2*ANGLE_W-1:0] buf_v;
    logic [ANGLE_W-1:0]          a_exp;
    logic [SCORE_W-1:0]          sc;
    int                          k;
    buf_v = '0;
    for (int c = 0; c < N_CAND; c++) begin
      m_theta[c] = ANGLE_W'($urandom);
      m_phi[c]   = ANGLE_W'($urandom);
      buf_v[c*2*ANGLE_W +: 2*ANGLE_W] = {m_theta[c], m_phi[c]};
    end
    cand_buf = buf_v;
    start    = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    cand_buf = ~buf_v;
    k = 0;
    for (int c = 0; c < N_CAND; c++) begin
      for (int s = 0; s < ALPHA_STEPS; s++) begin
        a_exp = ANGLE_W'(s * ALPHA_INC);
        check({tag, "_req_valid"}, 32'(req_valid), 1);
        check({tag, "_busy"},      32'(busy), 1);
        check({tag, "_theta"},     32'(theta), 32'(m_theta[c]));
        check({tag, "_phi"},       32'(phi), 32'(m_phi[c]));
        check({tag, "_alpha"},     32'(alpha), 32'(a_exp));
        check({tag, "_cand_idx"},  32'(cand_idx), 32'(c));
        check({tag, "_last"},      32'(last_angle),
              32'((c == N_CAND - 1) && (s == ALPHA_STEPS - 1)));
        for (int w = 0; w < stall; w++) begin
          req_ready = 1'b0;
          if (smode == 2) begin
            score_valid = 1'b1;
            score       = '1;
          end
          @(negedge clk);
          check({tag, "_stall_valid"}, 32'(req_valid), 1);
          check({tag, "_stall_theta"}, 32'(theta), 32'(m_theta[c]));
          check({tag, "_stall_alpha"}, 32'(alpha), 32'(a_exp));
        end
        score_valid = 1'b0;
        req_ready   = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
        check({tag, "_wait_valid"}, 32'(req_valid), 0);
        if (k == abort_k) begin
          abort = 1'b1;
          @(negedge clk);
          abort = 1'b0;
          check({tag, "_abort_busy"}, 32'(busy), 0);
          check({tag, "_abort_done"}, 32'(done), 0);
          score_valid = 1'b1;
          score       = '1;
          @(negedge clk);
          score_valid = 1'b0;
          check({tag, "_stray_busy"},  32'(busy), 0);
          check({tag, "_stray_valid"}, 32'(req_valid), 0);
          check_best({tag, "_abort"});
          return;
        end
        if (smode == 2) begin
          repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            check({tag, "_wait_hold"}, 32'(busy && !req_valid), 1);
          end
        end
        case (smode)
          0:       sc = SCORE_W'(c * 10 + int'(a_exp));
          1:       sc = SCORE_W'(5);
          default: sc = SCORE_W'($urandom_range(0, 7));
        endcase
        score_valid = 1'b1;
        score       = sc;
        @(negedge clk);
        score_valid = 1'b0;
        if (k == 0 || sc > mb_score) begin
          mb_theta = m_theta[c]; mb_phi = m_phi[c]; mb_alpha = a_exp;
          mb_score = sc;         mb_idx = c;
        end
        @(negedge clk);
        k++;
      end
    end
    check({tag, "_done"},      32'(done), 1);
    check({tag, "_done_busy"}, 32'(busy), 1);
    check({tag, "_done_valid"}, 32'(req_valid), 0);
    check_best(tag);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 0);
    check({tag, "_idle_busy"},  32'(busy), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; req_ready = 1'b0;
    score_valid = 1'b0; score = '0; cand_buf = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("abort_wins_busy", 32'(busy), 0);

    do_run("echo", 0, 0, -1, 1'b0);
    check("echo_idx_const",   32'(best_idx), 1);
    check("echo_alpha_const", 32'(best_alpha), 2);
    check("echo_score_const", 32'(best_score), 12);

    do_run("tie", 1, 0, -1, 1'b0);
    check("tie_idx_const",   32'(best_idx), 0);
    check("tie_alpha_const", 32'(best_alpha), 0);
    check("tie_score_const", 32'(best_score), 5);

    do_run("stall", 0, 4, -1, 1'b0);
    do_run("abort0", 2, 1, 0, 1'b0);
    do_run("abort2", 2, 2, 2, 1'b0);
    do_run("held1", 2, 0, -1, 1'b1);
    do_run("held2", 2, 1, -1, 1'b0);
    for (int i = 0; i < 6; i++) do_run("rand", 2, $urandom_range(0, 2), -1, 1'b0);

    cand_buf = {N_CAND{24'hABC_DEF}};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0; rst = 1'b1;
    @(negedge clk);
    check_all_zero("midrst");
    rst = 1'b0;
    @(negedge clk);
    do_run("post_rst", 0, 1, -1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
